pc_sequencer: RTL

//   Fetch-side controller that sequences the PC register. Issues instruction-memory

---
 rtl/pc_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: issues instruction fetches at the current PC and computes
// the next PC from sequential increment or a pending branch/jump/trap redirect.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    input  logic            trap_i,
    input  logic            imem_ack_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] oldpc_o,
    output logic            pc_load_o,
    output logic            misalign_o,
    output logic            halted_o,
    output logic [31:0]     fetch_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Redirect priority encoding; zero means nothing pending.
    localparam logic [1:0] PR_NONE   = 2'd0;
    localparam logic [1:0] PR_BRANCH = 2'd1;
    localparam logic [1:0] PR_JUMP   = 2'd2;
    localparam logic [1:0] PR_TRAP   = 2'd3;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [1:0]      state_r;
    logic [XLEN-1:0] pc_r;
    logic            hold_r;
    logic            halt_pend_r;
    logic [1:0]      pend_prio_r;
    logic [XLEN-1:0] pend_tgt_r;
    logic            pend_mis_r;
    logic [XLEN-1:0] oldpc_r;
    logic            pc_load_r;
    logic            misalign_r;
    logic            halted_r;
    logic [31:0]     fetch_cnt_r;

    logic [1:0]      in_prio_s;
    logic [XLEN-1:0] in_tgt_s;
    logic            in_mis_s;
    logic [1:0]      eff_prio_s;
    logic [XLEN-1:0] eff_tgt_s;
    logic            eff_mis_s;
    logic            eff_valid_s;
    logic            req_s;
    logic            ack_s;
    logic [XLEN-1:0] next_pc_s;

    // Encode this cycle's redirect request; misaligned targets become a trap.
    always_comb begin
        in_prio_s = PR_NONE;
        in_tgt_s  = {XLEN{1'b0}};
        in_mis_s  = 1'b0;
        if (trap_i) begin
            in_prio_s = PR_TRAP;
            in_tgt_s  = TRAP_VECTOR;
        end else if (jump_i) begin
            in_prio_s = PR_JUMP;
            in_mis_s  = is_misaligned(jump_tgt_i);
            in_tgt_s  = in_mis_s ? TRAP_VECTOR : jump_tgt_i;
        end else if (branch_i) begin
            in_prio_s = PR_BRANCH;
            in_mis_s  = is_misaligned(branch_tgt_i);
            in_tgt_s  = in_mis_s ? TRAP_VECTOR : branch_tgt_i;
        end else begin
            in_prio_s = PR_NONE;
        end
    end

    // Merge with the pending entry: a new request wins unless the pending one outranks it.
    always_comb begin
        eff_prio_s = pend_prio_r;
        eff_tgt_s  = pend_tgt_r;
        eff_mis_s  = pend_mis_r;
        if ((in_prio_s != PR_NONE) && (in_prio_s >= pend_prio_r)) begin
            eff_prio_s = in_prio_s;
            eff_tgt_s  = in_tgt_s;
            eff_mis_s  = in_mis_s;
        end else begin
            eff_prio_s = pend_prio_r;
        end
    end

    // Request stays up while outstanding; new requests are suppressed by stall or halt.
    always_comb begin
        eff_valid_s = (eff_prio_s != PR_NONE);
        req_s       = (state_r == ST_FETCH) &&
                      (hold_r || (!stall_i && !halt_i && !halt_pend_r));
        ack_s       = req_s && imem_ack_i;
        next_pc_s   = eff_valid_s ? eff_tgt_s : (pc_r + PC_STEP);
    end

    // Sequencer state, PC, pending redirect and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_VECTOR;
            hold_r      <= 1'b0;
            halt_pend_r <= 1'b0;
            pend_prio_r <= PR_NONE;
            pend_tgt_r  <= {XLEN{1'b0}};
            pend_mis_r  <= 1'b0;
            oldpc_r     <= RESET_VECTOR;
            pc_load_r   <= 1'b0;
            misalign_r  <= 1'b0;
            halted_r    <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else begin
            pc_load_r  <= 1'b0;
            misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_FETCH;
                    pend_prio_r <= eff_prio_s;
                    pend_tgt_r  <= eff_tgt_s;
                    pend_mis_r  <= eff_mis_s;
                end
                ST_FETCH: begin
                    hold_r <= req_s && !imem_ack_i;
                    if (ack_s) begin
                        pc_r        <= next_pc_s;
                        oldpc_r     <= next_pc_s;
                        pc_load_r   <= 1'b1;
                        misalign_r  <= eff_valid_s && eff_mis_s;
                        fetch_cnt_r <= fetch_cnt_r + 32'd1;
                        pend_prio_r <= PR_NONE;
                        pend_mis_r  <= 1'b0;
                    end else if (eff_valid_s && !req_s) begin
                        // Nothing in flight: apply the redirect straight to the PC.
                        pc_r        <= eff_tgt_s;
                        oldpc_r     <= eff_tgt_s;
                        pc_load_r   <= 1'b1;
                        misalign_r  <= eff_mis_s;
                        pend_prio_r <= PR_NONE;
                        pend_mis_r  <= 1'b0;
                    end else begin
                        pend_prio_r <= eff_prio_s;
                        pend_tgt_r  <= eff_tgt_s;
                        pend_mis_r  <= eff_mis_s;
                    end
                    if (halt_i || halt_pend_r) begin
                        if (!req_s || ack_s) begin
                            state_r     <= ST_HALT;
                            halted_r    <= 1'b1;
                            halt_pend_r <= 1'b0;
                            hold_r      <= 1'b0;
                        end else begin
                            halt_pend_r <= 1'b1;
                        end
                    end else begin
                        halt_pend_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    hold_r   <= 1'b0;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    hold_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_r;
    assign oldpc_o     = oldpc_r;
    assign pc_load_o   = pc_load_r;
    assign misalign_o  = misalign_r;
    assign halted_o    = halted_r;
    assign fetch_cnt_o = fetch_cnt_r;

endmodule
